// File: rtl/vend_gesture_ctrl.sv
// Vending machine sequencer: gesture/coin pulses drive select, pay, dispense and refund.
// Owns the beeper request and the segment display value/mode.
//
// state      | meaning
// S_IDLE     | blank display, waiting for any gesture
// S_SELECT   | browsing items, price shown
// S_PAY      | accumulating coins, paid amount shown
// S_DISPENSE | item released, change shown for the hold time
// S_REFUND   | money returned, refunded amount shown for the hold time
module vend_gesture_ctrl #(
    parameter logic [7:0]  PRICE0      = 8'd3,
    parameter logic [7:0]  PRICE1      = 8'd5,
    parameter logic [7:0]  PRICE2      = 8'd8,
    parameter logic [7:0]  PRICE3      = 8'd12,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_500_000_000,
    parameter logic [31:0] DISP_CYC    = 32'd100_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] gest,
    input  logic       coin_1,
    input  logic       coin_5,
    output logic [1:0] item,
    output logic [7:0] disp_val,
    output logic [1:0] disp_mode,
    output logic [1:0] beep_req,
    output logic       dispense,
    output logic       refund,
    output logic [3:0] state_led
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_PAY, S_DISPENSE, S_REFUND
    } state_t;

    localparam logic [1:0] BEEP_NONE  = 2'b00;
    localparam logic [1:0] BEEP_CLICK = 2'b01;
    localparam logic [1:0] BEEP_OK    = 2'b10;
    localparam logic [1:0] BEEP_ERR   = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  item_q, item_d;
    logic [7:0]  paid_q, paid_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  disp_val_q, disp_val_d;
    logic [1:0]  disp_mode_q, disp_mode_d;
    logic [1:0]  beep_q, beep_d;
    logic        dispense_q, dispense_d;
    logic        refund_q, refund_d;

    function automatic logic [7:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = PRICE0;
            2'd1:    price_of = PRICE1;
            2'd2:    price_of = PRICE2;
            default: price_of = PRICE3;
        endcase
    endfunction

    // Only a single asserted gesture bit counts; blank or chorded patterns are noise.
    logic       gest_ok, g_up, g_down, g_left, g_right, coin_any;
    logic [8:0] paid_sum;
    logic [7:0] paid_nx, price_cur;
    logic       paid_enough, tmo_hit, hold_done;

    assign gest_ok     = (gest != 4'd0) && ((gest & (gest - 4'd1)) == 4'd0);
    assign g_up        = gest_ok & gest[0];
    assign g_down      = gest_ok & gest[1];
    assign g_left      = gest_ok & gest[2];
    assign g_right     = gest_ok & gest[3];
    assign coin_any    = coin_1 | coin_5;
    assign paid_sum    = {1'b0, paid_q} + {8'd0, coin_1} + (coin_5 ? 9'd5 : 9'd0);
    assign paid_nx     = paid_sum[8] ? 8'hFF : paid_sum[7:0];
    assign price_cur   = price_of(item_q);
    assign paid_enough = paid_nx >= price_cur;
    assign tmo_hit     = cnt_q == (TIMEOUT_CYC - 32'd1);
    assign hold_done   = cnt_q == (DISP_CYC - 32'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            item_q      <= 2'd0;
            paid_q      <= 8'd0;
            cnt_q       <= 32'd0;
            disp_val_q  <= 8'd0;
            disp_mode_q <= 2'b00;
            beep_q      <= BEEP_NONE;
            dispense_q  <= 1'b0;
            refund_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            item_q      <= item_d;
            paid_q      <= paid_d;
            cnt_q       <= cnt_d;
            disp_val_q  <= disp_val_d;
            disp_mode_q <= disp_mode_d;
            beep_q      <= beep_d;
            dispense_q  <= dispense_d;
            refund_q    <= refund_d;
        end
    end

    // cnt_q is the idle timer in SELECT/PAY and the display hold timer afterwards.
    always_comb begin
        state_d = state_q;
        item_d  = item_q;
        paid_d  = paid_q;
        cnt_d   = cnt_q + 32'd1;
        case (state_q)
            S_IDLE: begin
                cnt_d = 32'd0;
                if (gest_ok) begin
                    state_d = S_SELECT;
                    item_d  = 2'd0;
                end
            end
            S_SELECT: begin
                if (gest_ok) begin
                    cnt_d = 32'd0;
                    if (g_up) begin
                        item_d = item_q + 2'd1;
                    end else if (g_down) begin
                        item_d = item_q - 2'd1;
                    end else if (g_right) begin
                        state_d = S_PAY;
                        paid_d  = 8'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                end
            end
            S_PAY: begin
                if (paid_enough) begin
                    state_d = S_DISPENSE;
                    paid_d  = paid_nx;
                    cnt_d   = 32'd0;
                end else if (g_left) begin
                    state_d = (paid_nx != 8'd0) ? S_REFUND : S_IDLE;
                    paid_d  = paid_nx;
                    cnt_d   = 32'd0;
                end else if (gest_ok || coin_any) begin
                    paid_d = paid_nx;
                    cnt_d  = 32'd0;
                end else if (tmo_hit) begin
                    state_d = (paid_q != 8'd0) ? S_REFUND : S_IDLE;
                    cnt_d   = 32'd0;
                end
            end
            S_DISPENSE, S_REFUND: begin
                if (hold_done) begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
        if (state_d == S_IDLE) paid_d = 8'd0;
    end

    always_comb begin
        dispense_d  = (state_q == S_PAY) && (state_d == S_DISPENSE);
        refund_d    = (state_q == S_PAY) && (state_d == S_REFUND);
        beep_d      = BEEP_NONE;
        disp_val_d  = disp_val_q;
        disp_mode_d = disp_mode_q;
        if (dispense_d) begin
            beep_d = BEEP_OK;
        end else if ((state_q == S_SELECT || state_q == S_PAY) &&
                     (state_d == S_IDLE || state_d == S_REFUND)) begin
            beep_d = BEEP_ERR;
        end else if ((state_q == S_IDLE && state_d == S_SELECT) ||
                     (state_q == S_SELECT && gest_ok) ||
                     (state_q == S_PAY && coin_any)) begin
            beep_d = BEEP_CLICK;
        end
        case (state_d)
            S_IDLE: begin
                disp_mode_d = 2'b00;
                disp_val_d  = 8'd0;
            end
            S_SELECT: begin
                disp_mode_d = 2'b01;
                disp_val_d  = price_of(item_d);
            end
            S_PAY: begin
                disp_mode_d = 2'b10;
                disp_val_d  = paid_d;
            end
            S_DISPENSE: begin
                disp_mode_d = 2'b11;
                if (state_q == S_PAY) disp_val_d = paid_nx - price_cur;
            end
            default: begin
                disp_mode_d = 2'b11;
                disp_val_d  = paid_d;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            S_IDLE:   state_led = 4'b0001;
            S_SELECT: state_led = 4'b0010;
            S_PAY:    state_led = 4'b0100;
            default:  state_led = 4'b1000;
        endcase
    end

    assign item      = item_q;
    assign disp_val  = disp_val_q;
    assign disp_mode = disp_mode_q;
    assign beep_req  = beep_q;
    assign dispense  = dispense_q;
    assign refund    = refund_q;

endmodule

// File: tb/tb_vend_gesture_ctrl.sv
// Scoreboard bench for vend_gesture_ctrl: a behavioural model queues expected output events,
// a monitor compares them against every beep/pulse/state change the DUT shows.
module tb_vend_gesture_ctrl;

    localparam int TMO = 100;
    localparam int DC  = 20;
    localparam int PH_IDLE = 0, PH_SEL = 1, PH_PAY = 2, PH_DISP = 3, PH_REF = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] gest = 4'd0;
    logic       coin_1 = 1'b0, coin_5 = 1'b0;
    logic [1:0] item, disp_mode, beep_req;
    logic [7:0] disp_val;
    logic       dispense, refund;
    logic [3:0] state_led;

    vend_gesture_ctrl #(
        .PRICE0(8'd3), .PRICE1(8'd5), .PRICE2(8'd8), .PRICE3(8'd12),
        .TIMEOUT_CYC(32'd100), .DISP_CYC(32'd20)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .gest(gest),
        .coin_1(coin_1), .coin_5(coin_5), .item(item), .disp_val(disp_val),
        .disp_mode(disp_mode), .beep_req(beep_req), .dispense(dispense),
        .refund(refund), .state_led(state_led)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc; int led; int item; int val; int mode; int beep; int dsp; int rfd;
    } ev_t;
    ev_t exp_q[$];

    int n_chk = 0, n_pass = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Behavioural reference model
    int price_tab[4] = '{3, 5, 8, 12};
    int m_ph = PH_IDLE, m_item = 0, m_paid = 0, m_quiet = 0, m_hold = 0, m_dval = 0, m_dmode = 0;

    function automatic int led_of(input int ph);
        case (ph)
            PH_IDLE: return 1;
            PH_SEL:  return 2;
            PH_PAY:  return 4;
            default: return 8;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_item = 0; m_paid = 0; m_quiet = 0; m_hold = 0; m_dval = 0; m_dmode = 0;
    endtask

    task automatic model_step(input logic [3:0] g, input logic c1, input logic c5);
        int nph, beep, pn;
        bit dsp, rfd, valid;
        ev_t e;
        valid = ($countones(g) == 1);
        nph = m_ph; beep = 0; dsp = 0; rfd = 0;
        case (m_ph)
            PH_IDLE: if (valid) begin nph = PH_SEL; m_item = 0; beep = 1; end
            PH_SEL: begin
                if (valid) begin
                    m_quiet = 0;
                    if (g == 4'b0001)      begin m_item = (m_item + 1) % 4; beep = 1; end
                    else if (g == 4'b0010) begin m_item = (m_item + 3) % 4; beep = 1; end
                    else if (g == 4'b1000) begin nph = PH_PAY; m_paid = 0; beep = 1; end
                    else                   begin nph = PH_IDLE; beep = 3; end
                end else if (m_quiet + 1 == TMO) begin nph = PH_IDLE; beep = 3; end
                else m_quiet++;
            end
            PH_PAY: begin
                pn = m_paid + (c1 ? 1 : 0) + (c5 ? 5 : 0);
                if (pn > 255) pn = 255;
                if (pn >= price_tab[m_item]) begin
                    nph = PH_DISP; dsp = 1; beep = 2; m_dval = pn - price_tab[m_item];
                end else if (valid && g == 4'b0100) begin
                    beep = 3;
                    if (pn > 0) begin nph = PH_REF; rfd = 1; m_dval = pn; end
                    else nph = PH_IDLE;
                end else if (valid || c1 || c5) begin
                    m_paid = pn; m_quiet = 0;
                    if (c1 || c5) beep = 1;
                end else if (m_quiet + 1 == TMO) begin
                    beep = 3;
                    if (m_paid > 0) begin nph = PH_REF; rfd = 1; m_dval = m_paid; end
                    else nph = PH_IDLE;
                end else m_quiet++;
            end
            default: begin
                m_hold++;
                if (m_hold == DC) nph = PH_IDLE;
            end
        endcase
        if (nph != m_ph) begin m_quiet = 0; m_hold = 0; end
        if (nph == PH_IDLE)     begin m_paid = 0; m_dval = 0; m_dmode = 0; end
        else if (nph == PH_SEL) begin m_dval = price_tab[m_item]; m_dmode = 1; end
        else if (nph == PH_PAY) begin m_dval = m_paid; m_dmode = 2; end
        else m_dmode = 3;
        if (beep != 0 || dsp || rfd || led_of(nph) != led_of(m_ph)) begin
            e.cyc = cyc + 1; e.led = led_of(nph); e.item = m_item; e.val = m_dval;
            e.mode = m_dmode; e.beep = beep; e.dsp = dsp; e.rfd = rfd;
            exp_q.push_back(e);
        end
        m_ph = nph;
    endtask

    task automatic tick(input logic [3:0] g, input logic c1, input logic c5);
        @(negedge sys_clk);
        gest = g; coin_1 = c1; coin_5 = c5;
        model_step(g, c1, c5);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(4'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_item", item, 0);
        chk("rst_disp_val", disp_val, 0);
        chk("rst_disp_mode", disp_mode, 0);
        chk("rst_beep", beep_req, 0);
        chk("rst_dispense", dispense, 0);
        chk("rst_refund", refund, 0);
        chk("rst_state_led", state_led, 1);
    endtask

    // Monitor: every visible output event must match the head of the expected queue.
    initial begin
        logic [3:0] prev_led;
        ev_t e;
        prev_led = 4'b0001;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && mon_en &&
                (beep_req != 2'd0 || dispense || refund || state_led != prev_led)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event_cycle", cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_cycle", cyc, e.cyc);
                    chk("ev_state_led", state_led, e.led);
                    chk("ev_item", item, e.item);
                    chk("ev_disp_val", disp_val, e.val);
                    chk("ev_disp_mode", disp_mode, e.mode);
                    chk("ev_beep", beep_req, e.beep);
                    chk("ev_dispense", dispense, e.dsp);
                    chk("ev_refund", refund, e.rfd);
                end
            end
            prev_led = state_led;
        end
    end

    initial begin
        int seen, seen_val;
        logic [3:0] g;
        repeat (3) @(posedge sys_clk);
        #1 chk_reset_vals();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        mon_en = 1'b1;
        model_reset();

        // first gesture opens SELECT at item 0
        tick(4'b0001, 0, 0); idle(1);
        chk("sel_disp_val", disp_val, 3);
        chk("sel_disp_mode", disp_mode, 1);
        chk("sel_beep", beep_req, 1);
        tick(4'b0010, 0, 0); idle(1);
        chk("wrap_down_item", item, 3);
        chk("wrap_down_val", disp_val, 12);
        tick(4'b0001, 0, 0); idle(1);
        chk("wrap_up_item", item, 0);

        // item 2: 5 + 1 + 5 = 11, change 3
        tick(4'b0001, 0, 0); tick(4'b0001, 0, 0); tick(4'b1000, 0, 0);
        tick(4'b0000, 0, 1); idle(1);
        chk("paid_5", disp_val, 5);
        tick(4'b0000, 1, 0); idle(1);
        chk("paid_6", disp_val, 6);
        tick(4'b0000, 0, 1); idle(1);
        chk("disp_pulse", dispense, 1);
        chk("disp_change", disp_val, 3);
        chk("disp_beep", beep_req, 2);
        idle(1);
        chk("disp_pulse_once", dispense, 0);
        idle(DC + 2);
        chk("disp_back_idle", state_led, 1);

        // item 1, both coins in one cycle
        tick(4'b1000, 0, 0); tick(4'b0001, 0, 0); tick(4'b1000, 0, 0);
        tick(4'b0000, 1, 1); idle(1);
        chk("dual_coin_disp", dispense, 1);
        chk("dual_coin_change", disp_val, 1);
        idle(DC + 2);

        // item 3, pay 5, cancel
        tick(4'b0001, 0, 0); tick(4'b0010, 0, 0); tick(4'b1000, 0, 0);
        tick(4'b0000, 0, 1); tick(4'b0100, 0, 0); idle(1);
        chk("cancel_refund", refund, 1);
        chk("cancel_amount", disp_val, 5);
        chk("cancel_beep", beep_req, 3);
        idle(DC + 2);

        // item 0: left together with the completing coin dispenses
        tick(4'b0001, 0, 0); tick(4'b1000, 0, 0);
        tick(4'b0000, 1, 0); tick(4'b0000, 1, 0);
        tick(4'b0100, 1, 0); idle(1);
        chk("left_vs_coin_disp", dispense, 1);
        chk("left_vs_coin_refund", refund, 0);
        idle(DC + 2);

        // item 0, paid 1, then silence; a chorded gesture must not restart the timer
        tick(4'b0001, 0, 0); tick(4'b1000, 0, 0); tick(4'b0000, 1, 0);
        seen = 0; seen_val = -1;
        for (int i = 1; i <= 130; i++) begin
            tick((i == 50) ? 4'b0011 : 4'b0000, 0, 0);
            if (refund && seen == 0) begin seen = i; seen_val = disp_val; end
        end
        chk("timeout_refund_at", seen, TMO + 1);
        chk("timeout_refund_amt", seen_val, 1);

        // reset in the middle of a dispense hold
        tick(4'b0001, 0, 0); tick(4'b1000, 0, 0);
        tick(4'b0000, 1, 0); tick(4'b0000, 1, 0); tick(4'b0000, 1, 0);
        idle(5);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1 chk_reset_vals();
        chk("rst_pending_events", exp_q.size(), 0);
        model_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(DC + 5);
        chk("rst_no_late_pulse", exp_q.size(), 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8)       g = 4'b0001 << $urandom_range(0, 3);
            else if (r < 10) g = 4'($urandom_range(0, 15));
            else             g = 4'd0;
            tick(g, ($urandom_range(0, 14) == 0), ($urandom_range(0, 29) == 0));
        end
        idle(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vend_gesture_ctrl.md
Name: vend_gesture_ctrl

Overview:
Top-level sequencing controller for the gesture-operated vending machine. It consumes one-cycle gesture pulses from the PAJ7620 edge-detect stage and coin pulses, and steps through select, pay, dispense and refund. It is the single owner of the beeper and the 7-segment display: it issues beep-type requests to the beep block and value/mode words to the dynamic segment driver.

Parameters:
PRICE0, 8'd3, price of item 0 in yuan
PRICE1, 8'd5, price of item 1
PRICE2, 8'd8, price of item 2
PRICE3, 8'd12, price of item 3
TIMEOUT_CYC, 32'd1_500_000_000, idle cycles in SELECT/PAY before abort (30 s at 50 MHz)
DISP_CYC, 32'd100_000_000, hold time of DISPENSE/REFUND result display (2 s)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous active-low reset
gest  in  4  gesture pulses, one cycle each: [0] up, [1] down, [2] left/cancel, [3] right/confirm
coin_1  in  1  one-cycle pulse, 1 yuan inserted
coin_5  in  1  one-cycle pulse, 5 yuan inserted
item  out  2  currently selected item index
disp_val  out  8  binary value for the segment driver
disp_mode  out  2  00 idle/blank, 01 price, 10 paid, 11 change/refund
beep_req  out  2  one-cycle request: 01 key click, 10 success, 11 error/cancel, 00 none
dispense  out  1  one-cycle pulse, release item[]
refund  out  1  one-cycle pulse, return disp_val yuan
state_led  out  4  one-hot current state for board LEDs (IDLE, SELECT, PAY, DONE)

Behaviour:
- Reset (async, asynchronous assert): state IDLE, item=0, paid=0, timers=0, disp_val=0, disp_mode=00, beep_req=00, dispense=0, refund=0, state_led=4'b0001.
- Registered outputs; all responses are visible exactly 1 cycle after the triggering input edge.
- gest is valid only when one-hot. 4'b0000 or multi-bit patterns are ignored entirely: no beep, no timer reset.
- States: IDLE, SELECT, PAY, DISPENSE, REFUND. state_led: IDLE=0001, SELECT=0010, PAY=0100, DISPENSE or REFUND=1000.
- IDLE: disp_mode=00.
  - Any valid gesture -> SELECT, item=0, beep 01.
  - Coins in IDLE are ignored.
- SELECT: disp_mode=01, disp_val=PRICE[item].
  - up: item+1, wrapping 3->0.
  - down: item-1, wrapping 0->3.
  - Both up and down beep 01.
  - right -> PAY, paid=0, beep 01.
  - left -> IDLE, beep 11.
  - Coins are ignored.
- PAY: disp_mode=10, disp_val=paid.
  - Per cycle: paid_next = paid + (coin_1 ? 1 : 0) + (coin_5 ? 5 : 0), saturating at 255. Both coins in the same cycle add 6.
  - Each accepted coin beeps 01.
  - If paid_next >= PRICE[item] -> DISPENSE. This check takes priority over a left gesture in the same cycle.
  - Otherwise, left with paid_next>0 -> REFUND with amount paid_next; left with paid_next=0 -> IDLE. Either way beep 11.
  - up, down and right are ignored in PAY.
- DISPENSE entry cycle:
  - dispense=1 for 1 cycle.
  - change = paid_next - PRICE[item]; disp_mode=11, disp_val=change.
  - beep 10.
  - Hold DISP_CYC cycles, then -> IDLE with paid=0.
  - All inputs are ignored during the hold.
- REFUND entry cycle:
  - refund=1 for 1 cycle, disp_mode=11, disp_val=refunded amount, beep 11.
  - Hold DISP_CYC cycles, then -> IDLE with paid=0.
- Timeout counter (SELECT and PAY only):
  - Increments every cycle.
  - Clears on any valid gesture or accepted coin, and on state entry.
  - At TIMEOUT_CYC-1: SELECT -> IDLE; PAY -> REFUND if paid>0, else IDLE. Beep 11 in all cases.
- beep_req returns to 00 on the cycle after any request. At most one request is issued per cycle; priority is 10 > 11 > 01.
- Prices are compared as 8-bit unsigned values; change is never negative.
- Reset asserted mid-dispense cancels the hold with no further pulses. Coins held at that moment are not tracked.

Test Plan:
Use TIMEOUT_CYC=100, DISP_CYC=20, default prices.
- Reset, then gest=0001 -> SELECT, item=0, disp_mode=01, disp_val=3, beep_req=01 for 1 cycle.
- From SELECT item=0: down -> item=3, disp_val=12; up -> item=0. Wrap is verified both ways.
- Select item 2, right, then coin_5, coin_1, coin_5 -> paid shows 5, 6; the third coin gives dispense=1 for 1 cycle, disp_val=3 (11-8), beep 10, then IDLE after 20 cycles.
- Item 1, PAY, coin_1 and coin_5 in the same cycle -> paid=6 >= 5 -> dispense, change=1.
- PAY item 3, insert 5, then left -> refund=1, disp_val=5, beep 11.
  - Also: left and the coin completing the price in the same cycle -> dispense, not refund.
- PAY item 0 with paid=1, no input for 100 cycles -> refund=1, disp_val=1.
  - Also: gest=0011 ignored (timer keeps running); reset asserted during DISPENSE hold -> all outputs return to reset values immediately.
